// File: rtl/dff_mem_burst_initiator.sv
// Burst command initiator for the DFF RAM macro port: sequences write/read beats
// with wrapping addresses and summarises returned read bytes (sum, mismatch count).
module dff_mem_burst_initiator #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_lr_n,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W:0]   err_cnt
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN  = (ADDR_W+1)'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     remain_reg, remain_next;
  logic [1:0]          op_reg, op_next;
  logic [DATA_W-1:0]   expect_reg, expect_next;
  logic                cap_reg, cap_next;
  logic                cmd_ready_reg, cmd_ready_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic                mem_ce_n_reg, mem_ce_n_next;
  logic                mem_lr_n_reg, mem_lr_n_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                rd_valid_reg, rd_valid_next;
  logic [DATA_W-1:0]   rd_data_reg, rd_data_next;
  logic                done_reg, done_next;
  logic [DATA_W-1:0]   result_reg, result_next;
  logic [ADDR_W:0]     err_cnt_reg, err_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      remain_reg    <= '0;
      op_reg        <= '0;
      expect_reg    <= '0;
      cap_reg       <= 1'b0;
      cmd_ready_reg <= 1'b1;
      mem_addr_reg  <= '0;
      mem_ce_n_reg  <= 1'b1;
      mem_lr_n_reg  <= 1'b1;
      mem_wdata_reg <= '0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      remain_reg    <= remain_next;
      op_reg        <= op_next;
      expect_reg    <= expect_next;
      cap_reg       <= cap_next;
      cmd_ready_reg <= cmd_ready_next;
      mem_addr_reg  <= mem_addr_next;
      mem_ce_n_reg  <= mem_ce_n_next;
      mem_lr_n_reg  <= mem_lr_n_next;
      mem_wdata_reg <= mem_wdata_next;
      rd_valid_reg  <= rd_valid_next;
      rd_data_reg   <= rd_data_next;
      done_reg      <= done_next;
      result_reg    <= result_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remain_next    = remain_reg;
    op_next        = op_reg;
    expect_next    = expect_reg;
    cap_next       = 1'b0;
    cmd_ready_next = cmd_ready_reg;
    mem_addr_next  = mem_addr_reg;
    mem_ce_n_next  = mem_ce_n_reg;
    mem_lr_n_next  = mem_lr_n_reg;
    mem_wdata_next = mem_wdata_reg;
    rd_valid_next  = 1'b0;
    rd_data_next   = rd_data_reg;
    done_next      = 1'b0;
    result_next    = result_reg;
    err_cnt_next   = err_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          // The first beat is put on the bus by this edge, so it appears in cycle 1.
          op_next        = cmd_op;
          expect_next    = cmd_data;
          result_next    = '0;
          err_cnt_next   = '0;
          remain_next    = (cmd_len == '0) ? FULL_LEN : {1'b0, cmd_len};
          mem_addr_next  = cmd_addr;
          mem_ce_n_next  = 1'b0;
          mem_lr_n_next  = cmd_op[1];
          cmd_ready_next = 1'b0;
          if (!cmd_op[1]) begin
            mem_wdata_next = cmd_data;
            state_next     = WRITE;
          end else begin
            state_next     = READ;
          end
        end
      end
      WRITE: begin
        if (remain_reg == ONE_LEN) begin
          mem_ce_n_next = 1'b1;
          mem_lr_n_next = 1'b1;
          done_next     = 1'b1;
          state_next    = DONE;
        end else begin
          remain_next   = remain_reg - ONE_LEN;
          mem_addr_next = mem_addr_reg + ADDR_W'(1);
          if (op_reg[0]) mem_wdata_next = mem_wdata_reg + DATA_W'(1);
        end
      end
      READ: begin
        cap_next = 1'b1;
        if (remain_reg == ONE_LEN) begin
          mem_ce_n_next = 1'b1;
          state_next    = DRAIN;
        end else begin
          remain_next   = remain_reg - ONE_LEN;
          mem_addr_next = mem_addr_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        done_next  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        cmd_ready_next = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next     = IDLE;
        cmd_ready_next = 1'b1;
        mem_ce_n_next  = 1'b1;
        mem_lr_n_next  = 1'b1;
      end
    endcase

    // cap_reg marks the cycle where the RAM's registered output holds the previous beat's byte.
    if (cap_reg) begin
      rd_valid_next = 1'b1;
      rd_data_next  = mem_rdata;
      result_next   = result_reg + mem_rdata;
      expect_next   = expect_reg + DATA_W'(1);
      if (op_reg == 2'b11 && mem_rdata != expect_reg) err_cnt_next = err_cnt_reg + ONE_LEN;
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_ce_n  = mem_ce_n_reg;
  assign mem_lr_n  = mem_lr_n_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;
  assign done      = done_reg;
  assign result    = result_reg;
  assign err_cnt   = err_cnt_reg;

endmodule
